// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for the hazard controller    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_pkg;

    localparam int NREG_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 3;
    localparam int REG_ZERO      = 0;

    // Widest register index a stage entry can carry; narrower indices are zero-extended.
    localparam int RW_MAX = 8;

    localparam logic [4:0] OP_MULT = 5'b00110;
    localparam logic [4:0] OP_DIV  = 5'b00111;

    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rd;
        logic              wr;
        logic              load;
    } stage_t;

    localparam int STAGE_W = $bits(stage_t);

    function automatic logic f_writes(input stage_t e, input logic [RW_MAX-1:0] src);
        return e.valid & e.wr & (e.rd == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stage_shift.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_stage_shift : DEPTH-entry destination tracker, flat export  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hazard_stage_shift
    import pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  stage_t                   i_entry,
    output logic [DEPTH*STAGE_W-1:0] o_entries
);

    stage_t r_stage [1:DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage[1] <= '0;
        end else begin
            r_stage[1] <= i_entry;
        end
    end

    generate
        for (genvar k = 2; k <= DEPTH; k++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage[k] <= '0;
                end else begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
        end

        for (genvar k = 1; k <= DEPTH; k++) begin : g_out
            assign o_entries[(k-1)*STAGE_W +: STAGE_W] = r_stage[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : decode stall, operand bypass selects, long-op   |
// | scoreboard and saturating stall counter.            Rev 1.0        |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NREG  = NREG_DEFAULT,
    parameter int RW    = $clog2(NREG),
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int SW    = $clog2(DEPTH + 1),
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_dec_valid,
    input  logic [RW-1:0] i_dec_rs,
    input  logic [RW-1:0] i_dec_rt,
    input  logic          i_dec_use_rs,
    input  logic          i_dec_use_rt,
    input  logic [RW-1:0] i_dec_rd,
    input  logic          i_dec_wr,
    input  logic          i_dec_load,
    input  logic          i_dec_long,
    input  logic          i_flush,
    input  logic          i_long_done,
    input  logic          i_stall_clr,
    output logic          o_stall,
    output logic [SW-1:0] o_fwd_a,
    output logic [SW-1:0] o_fwd_b,
    output logic          o_long_busy,
    output logic [CW-1:0] o_stall_cnt
);

    logic [NREG-1:0]          r_pending;
    logic                     r_long_busy;
    logic [RW-1:0]            r_long_rd;
    logic [CW-1:0]            r_stall_cnt;

    logic [DEPTH*STAGE_W-1:0] w_entries;
    stage_t                   w_stage [1:DEPTH];
    stage_t                   w_s1_in;
    logic [RW_MAX-1:0]        w_rs_x;
    logic [RW_MAX-1:0]        w_rt_x;
    logic                     w_rs_match;
    logic                     w_rt_match;
    logic                     w_load_use;
    logic                     w_raw;
    logic                     w_waw;
    logic                     w_struct;
    logic                     w_stall;
    logic                     w_issue;
    logic [SW-1:0]            w_fwd_a;
    logic [SW-1:0]            w_fwd_b;

    hazard_stage_shift #(
        .DEPTH (DEPTH)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_entry   (w_s1_in),
        .o_entries (w_entries)
    );

    generate
        for (genvar k = 1; k <= DEPTH; k++) begin : g_unpack
            assign w_stage[k] = w_entries[(k-1)*STAGE_W +: STAGE_W];
        end
    endgenerate

    assign w_rs_x     = RW_MAX'(i_dec_rs);
    assign w_rt_x     = RW_MAX'(i_dec_rt);
    assign w_rs_match = i_dec_use_rs & (i_dec_rs != RW'(REG_ZERO));
    assign w_rt_match = i_dec_use_rt & (i_dec_rt != RW'(REG_ZERO));

    assign w_load_use = w_stage[1].valid & w_stage[1].wr & w_stage[1].load &
                        ((w_rs_match & (w_stage[1].rd == w_rs_x)) |
                         (w_rt_match & (w_stage[1].rd == w_rt_x)));
    assign w_raw      = (w_rs_match & r_pending[i_dec_rs]) |
                        (w_rt_match & r_pending[i_dec_rt]);
    // pending[0] is never set, so a write to r0 cannot raise a WAW stall.
    assign w_waw      = i_dec_wr & r_pending[i_dec_rd];
    assign w_struct   = i_dec_long & r_long_busy;

    assign w_stall = i_dec_valid & ~i_flush & (w_load_use | w_raw | w_waw | w_struct);
    assign w_issue = i_dec_valid & ~w_stall & ~i_flush;

    always_comb begin
        w_s1_in = '0;
        if (w_issue) begin
            w_s1_in.valid = 1'b1;
            w_s1_in.rd    = RW_MAX'(i_dec_rd);
            w_s1_in.wr    = i_dec_wr & ~i_dec_long;
            w_s1_in.load  = i_dec_load;
        end
    end

    // Scan oldest to youngest so the youngest producer wins; a load in execute is skipped.
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (f_writes(w_stage[k], w_rs_x) && !(k == 1 && w_stage[k].load)) begin
                w_fwd_a = SW'(k);
            end
            if (f_writes(w_stage[k], w_rt_x) && !(k == 1 && w_stage[k].load)) begin
                w_fwd_b = SW'(k);
            end
        end
        if (!w_rs_match) begin
            w_fwd_a = '0;
        end
        if (!w_rt_match) begin
            w_fwd_b = '0;
        end
    end

    // Issue of a long op and an effective long_done are mutually exclusive (structural stall).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_long_busy <= 1'b0;
            r_long_rd   <= '0;
        end else begin
            if (i_long_done && r_long_busy) begin
                r_pending[r_long_rd] <= 1'b0;
                r_long_busy          <= 1'b0;
            end
            if (w_issue && i_dec_long) begin
                if (i_dec_rd != RW'(REG_ZERO)) begin
                    r_pending[i_dec_rd] <= 1'b1;
                end
                r_long_busy <= 1'b1;
                r_long_rd   <= i_dec_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (i_stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CW'(1);
        end
    end

    assign o_stall     = w_stall;
    assign o_fwd_a     = w_fwd_a;
    assign o_fwd_b     = w_fwd_b;
    assign o_long_busy = r_long_busy;
    assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed scenarios plus random decode stream |
// | checked against an instruction-history model.       Rev 1.0        |
// +--------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_dec_valid;
    logic [4:0]  i_dec_rs;
    logic [4:0]  i_dec_rt;
    logic        i_dec_use_rs;
    logic        i_dec_use_rt;
    logic [4:0]  i_dec_rd;
    logic        i_dec_wr;
    logic        i_dec_load;
    logic        i_dec_long;
    logic        i_flush;
    logic        i_long_done;
    logic        i_stall_clr;
    logic        o_stall;
    logic [1:0]  o_fwd_a;
    logic [1:0]  o_fwd_b;
    logic        o_long_busy;
    logic [31:0] o_stall_cnt;

    pipe_hazard_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_dec_valid  (i_dec_valid),
        .i_dec_rs     (i_dec_rs),
        .i_dec_rt     (i_dec_rt),
        .i_dec_use_rs (i_dec_use_rs),
        .i_dec_use_rt (i_dec_use_rt),
        .i_dec_rd     (i_dec_rd),
        .i_dec_wr     (i_dec_wr),
        .i_dec_load   (i_dec_load),
        .i_dec_long   (i_dec_long),
        .i_flush      (i_flush),
        .i_long_done  (i_long_done),
        .i_stall_clr  (i_stall_clr),
        .o_stall      (o_stall),
        .o_fwd_a      (o_fwd_a),
        .o_fwd_b      (o_fwd_b),
        .o_long_busy  (o_long_busy),
        .o_stall_cnt  (o_stall_cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // History of the last three issue slots, youngest first (index 0 = execute).
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } rec_t;

    rec_t        m_hist[$];
    bit          m_pend[32];
    bit          m_busy;
    int          m_lrd;
    logic [31:0] m_cnt;

    task automatic m_reset();
        rec_t z;
        z = '{0, 0, 0, 0};
        m_hist = {};
        for (int i = 0; i < 3; i++) m_hist.push_back(z);
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_busy = 0;
        m_lrd  = 0;
        m_cnt  = 0;
    endtask

    function automatic bit m_src(input bit u, input int r);
        return u && (r != 0);
    endfunction

    function automatic bit m_stall();
        rec_t y;
        bit   hz;
        y  = m_hist[0];
        hz = 0;
        if (!i_dec_valid || i_flush) return 0;
        if (y.v && y.wr && y.ld &&
            ((m_src(i_dec_use_rs, int'(i_dec_rs)) && y.rd == int'(i_dec_rs)) ||
             (m_src(i_dec_use_rt, int'(i_dec_rt)) && y.rd == int'(i_dec_rt)))) hz = 1;
        if (m_src(i_dec_use_rs, int'(i_dec_rs)) && m_pend[i_dec_rs]) hz = 1;
        if (m_src(i_dec_use_rt, int'(i_dec_rt)) && m_pend[i_dec_rt]) hz = 1;
        if (i_dec_wr && m_pend[i_dec_rd]) hz = 1;
        if (i_dec_long && m_busy) hz = 1;
        return hz;
    endfunction

    function automatic int m_fwd(input bit u, input int r);
        rec_t e;
        if (!m_src(u, r)) return 0;
        for (int k = 1; k <= 3; k++) begin
            e = m_hist[k-1];
            if (e.v && e.wr && e.rd == r && !(k == 1 && e.ld)) return k;
        end
        return 0;
    endfunction

    task automatic look();
        #1;
        chk("stall", o_stall, m_stall());
        chk("fwd_a", o_fwd_a, m_fwd(i_dec_use_rs, int'(i_dec_rs)));
        chk("fwd_b", o_fwd_b, m_fwd(i_dec_use_rt, int'(i_dec_rt)));
        chk("long_busy", o_long_busy, m_busy);
        chk("stall_cnt", o_stall_cnt, m_cnt);
    endtask

    task automatic adv();
        bit   st;
        bit   iss;
        rec_t e;
        st  = m_stall();
        iss = i_dec_valid && !st && !i_flush;
        e   = '{0, 0, 0, 0};
        if (iss) e = '{1, int'(i_dec_rd), i_dec_wr && !i_dec_long, i_dec_load};
        m_hist.push_front(e);
        void'(m_hist.pop_back());
        if (i_long_done && m_busy) begin
            m_pend[m_lrd] = 0;
            m_busy        = 0;
        end
        if (iss && i_dec_long) begin
            if (i_dec_rd != 0) m_pend[i_dec_rd] = 1;
            m_busy = 1;
            m_lrd  = int'(i_dec_rd);
        end
        if (i_stall_clr) m_cnt = 0;
        else if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        @(negedge clk);
    endtask

    task automatic idle();
        i_dec_valid  = 0;
        i_dec_rs     = 0;
        i_dec_rt     = 0;
        i_dec_use_rs = 0;
        i_dec_use_rt = 0;
        i_dec_rd     = 0;
        i_dec_wr     = 0;
        i_dec_load   = 0;
        i_dec_long   = 0;
        i_flush      = 0;
        i_long_done  = 0;
        i_stall_clr  = 0;
    endtask

    task automatic dec(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit wr, input bit ld, input bit lg);
        i_dec_valid  = v;
        i_dec_rs     = 5'(rs);
        i_dec_use_rs = urs;
        i_dec_rt     = 5'(rt);
        i_dec_use_rt = urt;
        i_dec_rd     = 5'(rd);
        i_dec_wr     = wr;
        i_dec_load   = ld;
        i_dec_long   = lg;
    endtask

    task automatic clear_cnt();
        idle();
        i_stall_clr = 1;
        look();
        adv();
        i_stall_clr = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_reset();
        repeat (2) @(negedge clk);
        look();
        rst_n = 1;
        @(negedge clk);

        // ALU chain
        dec(1, 1, 1, 2, 1, 3, 1, 0, 0);
        look(); adv();
        dec(1, 3, 1, 2, 1, 4, 1, 0, 0);
        look(); chk("alu_stall", o_stall, 0); chk("alu_fwd1", o_fwd_a, 1); adv();
        dec(1, 5, 1, 3, 1, 6, 1, 0, 0);
        look(); chk("alu_fwd2", o_fwd_b, 2); adv();

        // Load-use
        clear_cnt();
        dec(1, 1, 1, 0, 0, 5, 1, 1, 0);
        look(); adv();
        dec(1, 5, 1, 0, 0, 8, 1, 0, 0);
        look(); chk("lu_stall", o_stall, 1); adv();
        look(); chk("lu_released", o_stall, 0); chk("lu_fwd", o_fwd_a, 2);
        chk("lu_cnt", o_stall_cnt, 1); adv();

        // Long-op RAW
        clear_cnt();
        dec(1, 1, 1, 0, 0, 7, 1, 0, 1);
        look(); adv();
        dec(1, 7, 1, 0, 0, 9, 1, 0, 0);
        repeat (4) begin
            look(); chk("raw_hold", o_stall, 1); adv();
        end
        i_long_done = 1;
        look(); chk("raw_done_cycle", o_stall, 1); adv();
        i_long_done = 0;
        look(); chk("raw_release", o_stall, 0); chk("raw_fwd0", o_fwd_a, 0);
        chk("raw_cnt", o_stall_cnt, 5); adv();

        // Structural, WAW, done with simultaneous long
        dec(1, 1, 1, 0, 0, 7, 1, 0, 1);
        look(); adv();
        dec(1, 1, 1, 0, 0, 7, 1, 0, 0);
        look(); chk("waw", o_stall, 1); adv();
        dec(1, 0, 0, 0, 0, 8, 1, 0, 1);
        look(); chk("struct", o_stall, 1); adv();
        i_long_done = 1;
        look(); chk("done_plus_long", o_stall, 1); chk("busy_before_done", o_long_busy, 1); adv();
        i_long_done = 0;
        look(); chk("long_issue_next", o_stall, 0); adv();
        idle();
        look(); chk("busy_div", o_long_busy, 1); adv();
        i_long_done = 1;
        look(); adv();
        i_long_done = 0;

        // Flush and zero register
        dec(1, 1, 1, 0, 0, 5, 1, 1, 0);
        look(); adv();
        dec(1, 5, 1, 0, 0, 6, 1, 0, 0);
        i_flush = 1;
        look(); chk("flush_nostall", o_stall, 0); adv();
        i_flush = 0;
        dec(1, 6, 1, 5, 1, 10, 1, 0, 0);
        look(); chk("flush_no_s1", o_fwd_a, 0); chk("flush_fwd_b", o_fwd_b, 2);
        chk("flush_stall", o_stall, 0); adv();
        dec(1, 1, 1, 0, 0, 0, 1, 0, 0);
        look(); adv();
        dec(1, 0, 1, 0, 1, 11, 1, 0, 0);
        look(); chk("zero_fwd_a", o_fwd_a, 0); chk("zero_fwd_b", o_fwd_b, 0);
        chk("zero_stall", o_stall, 0); adv();

        // Reset in the middle of a multiply
        dec(1, 1, 1, 0, 0, 9, 1, 0, 1);
        look(); adv();
        dec(1, 9, 1, 0, 0, 12, 1, 0, 0);
        look(); chk("pre_rst_stall", o_stall, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rst_busy", o_long_busy, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_cnt", o_stall_cnt, 0);
        chk("rst_fwd_a", o_fwd_a, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        idle();
        i_long_done = 1;
        look(); chk("done_ignored", o_long_busy, 0); adv();
        i_long_done = 0;
        look(); chk("busy_stays_low", o_long_busy, 0); adv();

        // Random decode stream
        repeat (1500) begin
            bit lg;
            lg = ($urandom_range(0, 7) == 0);
            dec($urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                !lg && ($urandom_range(0, 3) == 0), lg);
            i_flush     = ($urandom_range(0, 7) == 0);
            i_long_done = ($urandom_range(0, 4) == 0);
            i_stall_clr = ($urandom_range(0, 31) == 0);
            look();
            adv();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and bypass controller for the pipelined processor core. It replaces the hand-written per-stage bypass muxes and the multdiv-only stall flop with a single unit. The unit tracks destination registers of in-flight instructions across DEPTH post-decode stages, and holds a pending-write scoreboard for one outstanding long-latency (mult/div) operation. Every cycle it issues a decode stall, forwarding selects for both source operands, and a saturating stall-cycle counter.

## Interface
- NREG, 32, architectural register count; register 0 is hardwired zero
- RW, $clog2(NREG), register index width
- DEPTH, 3, tracked stages after decode (stage 1 = execute, 2 = memory, 3 = writeback)
- SW, $clog2(DEPTH+1), forward-select width
- CW, 32, stall counter width

- clock  in  1  master clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- dec_valid  in  1  decode holds a real instruction
- dec_rs, dec_rt  in  RW  source register indices
- dec_use_rs, dec_use_rt  in  1  source actually read
- dec_rd  in  RW  destination index
- dec_wr  in  1  instruction writes dec_rd
- dec_load  in  1  instruction is a load
- dec_long  in  1  instruction is mult/div
- flush  in  1  branch/jump resolved in execute; decode instruction is killed
- long_done  in  1  multdiv result ready and written this cycle
- stall_clr  in  1  synchronous clear of stall_cnt
- stall  out  1  hold fetch/decode, inject bubble into execute
- fwd_a, fwd_b  out  SW  0 = regfile value, k = bypass from stage k
- long_busy  out  1  a long operation is outstanding
- stall_cnt  out  CW  cycles with stall asserted, saturating

## Operation
- Stage entry fields: valid, rd, wr, load. Entries are held in s[1..DEPTH].
- Issue = dec_valid & ~stall & ~flush.
- Each cycle s[k] <= s[k-1] for k ≥ 2.
- s[1] <= decode fields on issue, otherwise a bubble (valid = 0).
- A long op issues into s[1] with wr = 0. On issue it sets pending[dec_rd] (if rd ≠ 0), sets long_busy and latches rd internally.
- long_done clears pending[latched rd] and long_busy. long_done while not busy is ignored.
- Matching source: use bit = 1, index ≠ 0.
- stall = dec_valid & ~flush & (any of):
  - load-use: a matching source equals s[1].rd with s[1].valid & wr & load
  - RAW on long: a matching source has pending set
  - WAW on long: dec_wr & pending[dec_rd]
  - structural: dec_long & long_busy
- Forward select for each source: the lowest k with s[k].valid & wr & rd == src. Otherwise 0.
  - A load found only at k = 1 never forwards, because it stalls instead.
  - Unused or zero sources select 0.
- flush suppresses issue and stall in the same cycle. Older entries are untouched. A flushed long op sets no pending bit.
- stall_cnt increments when stall = 1 and the counter is not all-ones. It holds at all-ones. stall_clr has priority over the increment.

## Timing
- stall, fwd_a and fwd_b are combinational from decode inputs and registered state; zero-cycle latency.
- Scoreboard and busy are read as registered values. A long_done in cycle t releases dependants in cycle t+1. In t+1 those dependants read the regfile with fwd = 0.
- Simultaneous long_done and a dec_long: stalls in t and issues in t+1.
- Reset (asynchronous, any time, including while a long op is busy):
  - all s[k].valid = 0, pending = 0, long_busy = 0, stall_cnt = 0
  - stall = 0, fwd_a = fwd_b = 0
- Simultaneous stall_clr and stall: the counter reads 0 next cycle.

## Structure
- pipe_pkg holds:
  - stage-entry typedef (valid, rd, wr, load)
  - opcode constants (mult 00110, div 00111)
  - REG_ZERO
  - default NREG/DEPTH
- One sub-module, hazard_stage_shift: the DEPTH-entry shift register with bubble insertion. It exports all entries flat for the forward comparators.
- The scoreboard, stall logic, forward priority encoders and counter stay in the top level.

## Test plan
- **ALU chain:** add r3 issued, then add r4 using r3 next cycle → stall = 0, fwd_a = 1. One cycle later, an instruction using r3 gets fwd = 2.
- **Load-use:** lw r5, then add using r5 → stall = 1 for exactly one cycle. Next cycle fwd = 2, stall_cnt = 1.
- **Long op RAW:** mul r7, dependant held in decode → stall stays high until the cycle after long_done, then fwd = 0. stall_cnt equals the cycles waited.
- **Structural and WAW:** second div while busy stalls. addi r7 with r7 pending stalls. long_done plus dec_long in the same cycle → issue one cycle later.
- **Flush and zero:** flush with a dependent decode → no stall, no s[1] entry. A source r0 behind a writer of r0 → fwd = 0, stall = 0.
- **Reset:** reset low mid-mult → long_busy = 0, stall_cnt = 0, stall = 0. Later long_done is ignored.
